// File: rtl/pc060ha_master_seq.sv
// Host-side sequencer for the PC060HA master port: turns byte-level SEND/RECV/
// SLVRST/FLAGS requests into nibble-wide index/data bus accesses with flag polling.
module pc060ha_master_seq #(
  parameter int STROBE     = 2,
  parameter int POLL_LIMIT = 255
) (
  input  logic       MCLK,
  input  logic       nRESET,
  input  logic       REQ,
  input  logic [1:0] OP,
  input  logic       CH,
  input  logic [7:0] WDATA,
  output logic       BUSY,
  output logic       ACK,
  output logic [7:0] RDATA,
  output logic       ERR,
  output logic       nMCS,
  output logic       nMRD,
  output logic       nMWR,
  output logic       MA0,
  output logic [3:0] MD_O,
  output logic       MD_OE,
  input  logic [3:0] MD_I
);

  localparam logic [1:0] OP_SEND   = 2'b00;
  localparam logic [1:0] OP_RECV   = 2'b01;
  localparam logic [1:0] OP_SLVRST = 2'b10;
  localparam logic [1:0] OP_FLAGS  = 2'b11;

  localparam logic [3:0] FLAG_IDX = 4'h4;

  localparam int            SW        = (STROBE > 1) ? $clog2(STROBE) : 1;
  localparam logic [SW-1:0] STB_LAST  = SW'(STROBE - 1);
  localparam logic [7:0]    POLL_LAST = 8'(POLL_LIMIT - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_POLL_IDX,
    ST_POLL_RD,
    ST_XFER_IDX,
    ST_XFER_LO,
    ST_XFER_HI
  } state_t;

  typedef enum logic [2:0] {
    PH_NONE,
    PH_SETUP,
    PH_STROBE,
    PH_HOLD,
    PH_GAP
  } phase_t;

  state_t        state_q;
  phase_t        phase_q;
  logic [1:0]    op_q;
  logic          ch_q;
  logic [7:0]    wdata_q;
  logic [7:0]    poll_cnt_q;
  logic [SW-1:0] stb_cnt_q;
  logic          acc_wr_q;
  logic [3:0]    rd_nib_q;
  logic [3:0]    lo_nib_q;
  logic          busy_q;
  logic          ack_q;
  logic [7:0]    rdata_q;
  logic          err_q;
  logic          nmcs_q;
  logic          nmrd_q;
  logic          nmwr_q;
  logic          ma0_q;
  logic [3:0]    md_o_q;
  logic          md_oe_q;

  // Decision taken as an access leaves GAP; CHECK costs no clock of its own.
  state_t     step_d;
  logic       finish_d;
  logic       timeout_d;
  logic       retry_d;
  logic       rdata_load_d;
  logic [7:0] rdata_d;
  logic       poll_pass;

  always_comb begin
    step_d       = state_q;
    finish_d     = 1'b0;
    timeout_d    = 1'b0;
    retry_d      = 1'b0;
    rdata_load_d = 1'b0;
    rdata_d      = rdata_q;
    poll_pass    = (op_q == OP_RECV) ? rd_nib_q[{1'b1, ch_q}] : ~rd_nib_q[{1'b0, ch_q}];
    case (state_q)
      ST_POLL_IDX: step_d = (op_q == OP_SLVRST) ? ST_XFER_LO : ST_POLL_RD;
      ST_POLL_RD: begin
        if (op_q == OP_FLAGS) begin
          finish_d     = 1'b1;
          rdata_load_d = 1'b1;
          rdata_d      = {4'b0000, rd_nib_q};
        end else if (poll_pass) begin
          step_d = ST_XFER_IDX;
        end else if (poll_cnt_q == POLL_LAST) begin
          finish_d  = 1'b1;
          timeout_d = 1'b1;
        end else begin
          retry_d = 1'b1;
          step_d  = ST_POLL_IDX;
        end
      end
      ST_XFER_IDX: step_d = ST_XFER_LO;
      ST_XFER_LO: begin
        if (op_q == OP_SLVRST) finish_d = 1'b1;
        else                   step_d   = ST_XFER_HI;
      end
      ST_XFER_HI: begin
        finish_d = 1'b1;
        if (op_q == OP_RECV) begin
          rdata_load_d = 1'b1;
          rdata_d      = {rd_nib_q, lo_nib_q};
        end
      end
      default: step_d = ST_IDLE;
    endcase
  end

  // Bus attributes of the access about to be launched at this edge.
  state_t     launch_st;
  logic       acc_ma0;
  logic       acc_wr;
  logic [3:0] acc_nib;

  always_comb begin
    launch_st = (phase_q == PH_GAP) ? step_d : state_q;
    acc_ma0   = 1'b1;
    acc_wr    = 1'b0;
    acc_nib   = 4'h0;
    case (launch_st)
      ST_POLL_IDX: begin
        acc_ma0 = 1'b0;
        acc_wr  = 1'b1;
        acc_nib = FLAG_IDX;
      end
      ST_XFER_IDX: begin
        acc_ma0 = 1'b0;
        acc_wr  = 1'b1;
        acc_nib = {2'b00, ch_q, 1'b0};
      end
      ST_XFER_LO: begin
        acc_wr  = (op_q != OP_RECV);
        acc_nib = (op_q == OP_SLVRST) ? {3'b000, wdata_q[0]} : wdata_q[3:0];
      end
      ST_XFER_HI: begin
        acc_wr  = (op_q != OP_RECV);
        acc_nib = wdata_q[7:4];
      end
      default: ;
    endcase
  end

  always_ff @(posedge MCLK or negedge nRESET) begin
    if (!nRESET) begin
      state_q    <= ST_IDLE;
      phase_q    <= PH_NONE;
      op_q       <= OP_SEND;
      ch_q       <= 1'b0;
      wdata_q    <= 8'h00;
      poll_cnt_q <= 8'h00;
      stb_cnt_q  <= '0;
      acc_wr_q   <= 1'b0;
      rd_nib_q   <= 4'h0;
      lo_nib_q   <= 4'h0;
      busy_q     <= 1'b0;
      ack_q      <= 1'b0;
      rdata_q    <= 8'h00;
      err_q      <= 1'b0;
      nmcs_q     <= 1'b1;
      nmrd_q     <= 1'b1;
      nmwr_q     <= 1'b1;
      ma0_q      <= 1'b0;
      md_o_q     <= 4'h0;
      md_oe_q    <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      case (phase_q)
        PH_NONE: begin
          if (state_q == ST_IDLE) begin
            if (REQ) begin
              op_q       <= OP;
              ch_q       <= CH;
              wdata_q    <= WDATA;
              poll_cnt_q <= 8'h00;
              busy_q     <= 1'b1;
              state_q    <= ST_POLL_IDX;
            end
          end else begin
            state_q  <= launch_st;
            phase_q  <= PH_SETUP;
            nmcs_q   <= 1'b0;
            ma0_q    <= acc_ma0;
            md_o_q   <= acc_wr ? acc_nib : 4'h0;
            md_oe_q  <= acc_wr;
            acc_wr_q <= acc_wr;
          end
        end
        PH_SETUP: begin
          phase_q   <= PH_STROBE;
          stb_cnt_q <= STB_LAST;
          if (acc_wr_q) nmwr_q <= 1'b0;
          else          nmrd_q <= 1'b0;
        end
        PH_STROBE: begin
          if (stb_cnt_q == '0) begin
            phase_q <= PH_HOLD;
            nmrd_q  <= 1'b1;
            nmwr_q  <= 1'b1;
            if (!acc_wr_q) rd_nib_q <= MD_I;
          end else begin
            stb_cnt_q <= stb_cnt_q - 1'b1;
          end
        end
        PH_HOLD: begin
          phase_q <= PH_GAP;
          nmcs_q  <= 1'b1;
          md_oe_q <= 1'b0;
        end
        PH_GAP: begin
          if (retry_d) poll_cnt_q <= poll_cnt_q + 8'd1;
          if (state_q == ST_XFER_LO) lo_nib_q <= rd_nib_q;
          if (finish_d) begin
            state_q <= ST_IDLE;
            phase_q <= PH_NONE;
            busy_q  <= 1'b0;
            ack_q   <= 1'b1;
            err_q   <= timeout_d;
            if (rdata_load_d) rdata_q <= rdata_d;
          end else begin
            // Next access starts straight after GAP, no idle clock between.
            state_q  <= launch_st;
            phase_q  <= PH_SETUP;
            nmcs_q   <= 1'b0;
            ma0_q    <= acc_ma0;
            md_o_q   <= acc_wr ? acc_nib : 4'h0;
            md_oe_q  <= acc_wr;
            acc_wr_q <= acc_wr;
          end
        end
        default: phase_q <= PH_NONE;
      endcase
    end
  end

  assign BUSY  = busy_q;
  assign ACK   = ack_q;
  assign RDATA = rdata_q;
  assign ERR   = err_q;
  assign nMCS  = nmcs_q;
  assign nMRD  = nmrd_q;
  assign nMWR  = nmwr_q;
  assign MA0   = ma0_q;
  assign MD_O  = md_o_q;
  assign MD_OE = md_oe_q;

endmodule

// File: tb/tb_pc060ha_master_seq.sv
// Scoreboard bench for pc060ha_master_seq: expected bus accesses and ACK responses
// are queued by the stimulus; negedge monitors pop and compare.
module tb_pc060ha_master_seq;

  localparam int STB = 2;
  localparam int PL  = 4;
  localparam int L   = STB + 3;

  localparam logic [1:0] OP_SEND   = 2'b00;
  localparam logic [1:0] OP_RECV   = 2'b01;
  localparam logic [1:0] OP_SLVRST = 2'b10;
  localparam logic [1:0] OP_FLAGS  = 2'b11;

  logic       MCLK   = 1'b0;
  logic       nRESET = 1'b0;
  logic       REQ    = 1'b0;
  logic [1:0] OP     = 2'b00;
  logic       CH     = 1'b0;
  logic [7:0] WDATA  = 8'h00;
  logic [3:0] MD_I   = 4'h0;
  logic       BUSY, ACK, ERR, nMCS, nMRD, nMWR, MA0, MD_OE;
  logic [7:0] RDATA;
  logic [3:0] MD_O;

  pc060ha_master_seq #(.STROBE(STB), .POLL_LIMIT(PL)) dut (
    .MCLK(MCLK), .nRESET(nRESET), .REQ(REQ), .OP(OP), .CH(CH), .WDATA(WDATA),
    .BUSY(BUSY), .ACK(ACK), .RDATA(RDATA), .ERR(ERR),
    .nMCS(nMCS), .nMRD(nMRD), .nMWR(nMWR), .MA0(MA0),
    .MD_O(MD_O), .MD_OE(MD_OE), .MD_I(MD_I)
  );

  always #5 MCLK = ~MCLK;

  int cyc = 0;
  always @(posedge MCLK) cyc <= cyc + 1;

  typedef struct packed {
    logic       ma0;
    logic       wr;
    logic [3:0] nib;
  } acc_t;

  typedef struct packed {
    logic [31:0] cyc;
    logic [7:0]  rdata;
    logic        chk_rdata;
    logic        err;
  } rsp_t;

  acc_t       exp_acc[$];
  rsp_t       exp_rsp[$];
  logic [3:0] rd_resp[$];
  logic [3:0] md_default = 4'h0;

  int errors = 0;
  int checks = 0;
  int txn    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Bus and response monitor; also plays the PC060HA for read accesses.
  logic       in_acc = 1'b0;
  acc_t       cur_acc;
  acc_t       ea;
  rsp_t       er;
  int         stb_cycles;
  logic       saw_wr, saw_rd;

  always @(negedge MCLK) begin
    if (!nRESET) begin
      in_acc = 1'b0;
    end else begin
      if (ACK) begin
        txn++;
        $display("txn %0d: ack at cycle %0d rdata=%02h err=%0b", txn, cyc, RDATA, ERR);
        if (exp_rsp.size() == 0) begin
          chk("unexpected_ack", 32'(exp_rsp.size()), 32'd1);
        end else begin
          er = exp_rsp.pop_front();
          chk("ack_cycle", 32'(cyc), er.cyc);
          chk("err", {31'd0, ERR}, {31'd0, er.err});
          if (er.chk_rdata) chk("rdata", {24'd0, RDATA}, {24'd0, er.rdata});
          chk("accesses_left", 32'(exp_acc.size()), 32'd0);
        end
      end
      if (!nMCS && !in_acc) begin
        in_acc      = 1'b1;
        cur_acc.ma0 = MA0;
        cur_acc.wr  = MD_OE;
        cur_acc.nib = MD_O;
        stb_cycles  = 0;
        saw_wr      = 1'b0;
        saw_rd      = 1'b0;
        if (!MD_OE) MD_I = (rd_resp.size() > 0) ? rd_resp.pop_front() : md_default;
      end else if (!nMCS && in_acc) begin
        if (!nMWR) begin saw_wr = 1'b1; stb_cycles++; end
        if (!nMRD) begin saw_rd = 1'b1; stb_cycles++; end
      end else if (nMCS && in_acc) begin
        in_acc = 1'b0;
        if (exp_acc.size() == 0) begin
          chk("extra_access", 32'(exp_acc.size()), 32'd1);
        end else begin
          ea = exp_acc.pop_front();
          chk("acc_ma0", {31'd0, cur_acc.ma0}, {31'd0, ea.ma0});
          chk("acc_dir", {31'd0, cur_acc.wr}, {31'd0, ea.wr});
          chk("strobe_sel", {30'd0, saw_wr, saw_rd}, ea.wr ? 32'd2 : 32'd1);
          chk("strobe_cycles", 32'(stb_cycles), 32'(STB));
          if (ea.wr) chk("acc_nib", {28'd0, cur_acc.nib}, {28'd0, ea.nib});
        end
      end
    end
  end

  task automatic pa(input logic ma0, input logic wr, input logic [3:0] nib);
    exp_acc.push_back('{ma0: ma0, wr: wr, nib: nib});
  endtask

  task automatic issue(input logic [1:0] op, input logic ch, input logic [7:0] wd,
                       input int n, input logic [7:0] rd, input logic chk_rd, input logic err);
    rsp_t r;
    @(negedge MCLK);
    REQ = 1'b1; OP = op; CH = ch; WDATA = wd;
    @(posedge MCLK);
    #1;
    REQ = 1'b0;
    chk("busy_on_accept", {31'd0, BUSY}, 32'd1);
    r.cyc       = 32'(cyc + 1 + n * L);
    r.rdata     = rd;
    r.chk_rdata = chk_rd;
    r.err       = err;
    exp_rsp.push_back(r);
  endtask

  task automatic wait_done(input string name);
    int t = 0;
    while (exp_rsp.size() != 0 && t < 400) begin
      @(negedge MCLK);
      t++;
    end
    checks++;
    if (exp_rsp.size() != 0) begin
      errors++;
      $display("FAIL %s_done: no ACK within %0d cycles, required one", name, t);
      exp_rsp.delete();
      exp_acc.delete();
      rd_resp.delete();
    end
  endtask

  initial begin
    int t;
    repeat (3) @(negedge MCLK);
    chk("rst_nMCS", {31'd0, nMCS}, 32'd1);
    chk("rst_strobes", {30'd0, nMRD, nMWR}, 32'd3);
    chk("rst_ma0_oe", {30'd0, MA0, MD_OE}, 32'd0);
    chk("rst_md_o", {28'd0, MD_O}, 32'd0);
    chk("rst_busy_ack_err", {29'd0, BUSY, ACK, ERR}, 32'd0);
    chk("rst_rdata", {24'd0, RDATA}, 32'd0);
    nRESET = 1'b1;

    // SEND CH0 0xA5, slot free at first poll
    pa(0, 1, 4'h4); pa(1, 0, 4'h0); pa(0, 1, 4'h0); pa(1, 1, 4'h5); pa(1, 1, 4'hA);
    rd_resp.push_back(4'h0);
    issue(OP_SEND, 1'b0, 8'hA5, 5, 8'h00, 1'b0, 1'b0);
    wait_done("send_a5");

    // RECV CH1, two failed polls then data 0x3, 0xC
    for (int i = 0; i < 3; i++) begin pa(0, 1, 4'h4); pa(1, 0, 4'h0); end
    pa(0, 1, 4'h2); pa(1, 0, 4'h0); pa(1, 0, 4'h0);
    rd_resp.push_back(4'h0); rd_resp.push_back(4'h0); rd_resp.push_back(4'h8);
    rd_resp.push_back(4'h3); rd_resp.push_back(4'hC);
    issue(OP_RECV, 1'b1, 8'h00, 9, 8'hC3, 1'b1, 1'b0);
    wait_done("recv_c3");

    // SEND CH1 against a permanently full slot: timeout after PL polls
    md_default = 4'h2;
    for (int i = 0; i < PL; i++) begin pa(0, 1, 4'h4); pa(1, 0, 4'h0); end
    issue(OP_SEND, 1'b1, 8'hFF, 2 * PL, 8'hC3, 1'b1, 1'b1);
    wait_done("send_timeout");
    md_default = 4'h0;

    // FLAGS read, with REQ pulses while busy that must be ignored
    pa(0, 1, 4'h4); pa(1, 0, 4'h0);
    rd_resp.push_back(4'hB);
    issue(OP_FLAGS, 1'b0, 8'h00, 2, 8'h0B, 1'b1, 1'b0);
    OP = OP_SEND;
    repeat (2) @(negedge MCLK);
    REQ = 1'b1;
    @(negedge MCLK);
    REQ = 1'b0;
    repeat (2) @(negedge MCLK);
    REQ = 1'b1;
    @(negedge MCLK);
    REQ = 1'b0;
    wait_done("flags_0b");

    // SLVRST assert, release, and release using only WDATA bit 0
    pa(0, 1, 4'h4); pa(1, 1, 4'h1);
    issue(OP_SLVRST, 1'b0, 8'h01, 2, 8'h00, 1'b0, 1'b0);
    wait_done("slvrst_1");
    pa(0, 1, 4'h4); pa(1, 1, 4'h0);
    issue(OP_SLVRST, 1'b0, 8'h00, 2, 8'h00, 1'b0, 1'b0);
    wait_done("slvrst_0");
    pa(0, 1, 4'h4); pa(1, 1, 4'h0);
    issue(OP_SLVRST, 1'b1, 8'hFE, 2, 8'h0B, 1'b1, 1'b0);
    wait_done("slvrst_fe");

    // Reset during the write strobe of the first data nibble of a SEND
    pa(0, 1, 4'h4); pa(1, 0, 4'h0); pa(0, 1, 4'h0); pa(1, 1, 4'hA); pa(1, 1, 4'h5);
    rd_resp.push_back(4'h0);
    issue(OP_SEND, 1'b0, 8'h5A, 5, 8'h00, 1'b0, 1'b0);
    t = 0;
    while (!(nMWR === 1'b0 && MA0 === 1'b1) && t < 100) begin
      @(negedge MCLK);
      t++;
    end
    chk("reach_dw_strobe", {31'd0, nMWR}, 32'd0);
    #2 nRESET = 1'b0;
    #1;
    chk("arst_nMWR_nMCS", {30'd0, nMWR, nMCS}, 32'd3);
    chk("arst_nMRD", {31'd0, nMRD}, 32'd1);
    chk("arst_md_oe", {31'd0, MD_OE}, 32'd0);
    chk("arst_ma0_md_o", {27'd0, MA0, MD_O}, 32'd0);
    chk("arst_busy_ack", {30'd0, BUSY, ACK}, 32'd0);
    chk("arst_rdata", {24'd0, RDATA}, 32'd0);
    exp_acc.delete();
    exp_rsp.delete();
    rd_resp.delete();
    repeat (2) @(negedge MCLK);
    nRESET = 1'b1;
    repeat (3) begin
      @(negedge MCLK);
      chk("post_rst_idle", {30'd0, BUSY, ACK}, 32'd0);
    end

    // Fresh SEND CH1 0x3C completes normally
    pa(0, 1, 4'h4); pa(1, 0, 4'h0); pa(0, 1, 4'h2); pa(1, 1, 4'hC); pa(1, 1, 4'h3);
    rd_resp.push_back(4'h0);
    issue(OP_SEND, 1'b1, 8'h3C, 5, 8'h00, 1'b1, 1'b0);
    wait_done("send_3c");

    repeat (5) @(negedge MCLK);
    chk("final_queue_empty", 32'(exp_acc.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc060ha_master_seq.md
# pc060ha_master_seq

Host-side sequencer that drives the master port of the PC060HA sound-communication chip. It turns single-byte requests from the main-CPU-side logic into the nibble-wide bus accesses that port expects: index writes, flag polling, and data-pair transfers. It sits between a simple request/acknowledge host interface and the nMCS/nMRD/nMWR/MA0/MD pins of the PC060HA.

## Interface
Parameters:
- STROBE, 2: clocks nMRD/nMWR are held low per access (≥1).
- POLL_LIMIT, 255: maximum flag reads before a SEND/RECV gives up (1..255).

Ports:
- MCLK  in  1  clock; all logic on rising edge.
- nRESET  in  1  reset, asynchronous, active-low.
- REQ  in  1  request; sampled only while BUSY=0.
- OP  in  2  00 SEND, 01 RECV, 10 SLVRST, 11 FLAGS.
- CH  in  1  channel: 0 = register pair 0/1, 1 = pair 2/3.
- WDATA  in  8  byte for SEND; bit 0 used by SLVRST.
- BUSY  out  1  operation in progress.
- ACK  out  1  one-clock completion pulse.
- RDATA  out  8  RECV byte, or {4'b0, flags} for FLAGS; held until next ACK.
- ERR  out  1  valid with ACK; 1 = poll timeout.
- nMCS, nMRD, nMWR  out  1 each  chip-select and strobes, active-low.
- MA0  out  1  0 = index register, 1 = data register.
- MD_O  out  4  data to the PC060HA.
- MD_OE  out  1  MD_O drive enable.
- MD_I  in  4  data from the PC060HA.

## Operation
- Bus access sub-FSM, length L = STROBE+3 clocks: SETUP (nMCS=0, MA0/MD_O/MD_OE valid, strobes high), STROBE×(strobe low), HOLD (strobe high, nMCS=0, MD_O held), GAP (nMCS=1, MD_OE=0). Reads sample MD_I at the last STROBE clock. MD_OE=1 only for write accesses, SETUP through HOLD.
- Access kinds: IW(n) = write nibble n with MA0=0; DW(d) = write with MA0=1; DR = read with MA0=1.
- Flag nibble from reg 4: bit0 = m→s pair0/1 full, bit1 = m→s pair2/3 full, bit2 = s→m pair0/1 full, bit3 = s→m pair2/3 full.
- Top FSM: IDLE → POLL_IDX (IW 4) → POLL_RD (DR) → CHECK → XFER_IDX → XFER_LO → XFER_HI → DONE → IDLE.
- SEND: poll until flag[CH] = 0; then IW(CH?2:0), DW(WDATA[3:0]), DW(WDATA[7:4]). The high nibble relies on index auto-increment even→odd.
- RECV: poll until flag[2+CH] = 1; then IW(CH?2:0), DR → RDATA[3:0], DR → RDATA[7:4].
- FLAGS: IW 4, DR → RDATA = {4'b0, nibble}; no CHECK.
- SLVRST: IW 4, DW({3'b0, WDATA[0]}). Writing 1 holds the slave in reset; writing 0 releases it.
- CHECK fail with poll count < POLL_LIMIT: increment count and return to POLL_IDX. Fail at POLL_LIMIT: DONE with ERR=1; no transfer accesses; RDATA unchanged.
- REQ with BUSY=1 is ignored; there is no queue. OP, CH and WDATA are captured on the accepting edge.

## Timing
- Reset values: nMCS=nMRD=nMWR=1, MA0=0, MD_O=0, MD_OE=0, BUSY=0, ACK=0, RDATA=0, ERR=0; FSMs in IDLE; poll count 0.
- REQ=1 in IDLE at edge k: BUSY=1 from k; first SETUP in clock k+1.
- With n accesses, ACK=1 during clock k+1+n·L, and BUSY falls at the same edge. A new REQ is accepted at the edge after ACK.
- Accesses per op: FLAGS and SLVRST n=2; SEND/RECV with r failed polls n=5+2r; timeout n=2·POLL_LIMIT.
- With STROBE=2 (L=5): SEND with no retry gives ACK at k+26; FLAGS gives ACK at k+11.
- Consecutive accesses are back-to-back, with GAP as the only separator; nMCS is never low across a GAP.
- Asynchronous reset mid-access returns all outputs to reset values immediately; no partial nibble completes.

## Test plan
- SEND CH=0 WDATA=0xA5, flags model returns 0x0 → bus shows IW4, DR, IW0, DW5, DWA with MA0=0,1,0,1,1; ACK at k+26, ERR=0.
- RECV CH=1, flags read 0x0 twice then 0x8, model data 0x3 then 0xC → 9 accesses, RDATA=0xC3, ACK at k+46.
- POLL_LIMIT=4, SEND CH=1, flags fixed 0x2 → exactly 8 accesses, no DW, ERR=1, ACK at k+41, RDATA unchanged.
- FLAGS with MD_I=0xB on read → RDATA=0x0B, ERR=0, ACK at k+11; REQ pulses while BUSY=1 produce no extra accesses.
- SLVRST WDATA=0x01, then SLVRST WDATA=0x00 → DW nibbles 0x1 then 0x0 on MA0=1 after IW4; two ACKs.
- Assert nRESET during the STROBE phase of DW in a SEND → nMWR, nMCS go to 1 and MD_OE to 0 immediately; BUSY=0, no ACK; a fresh SEND afterwards completes normally.
